cdc_event_scheduler: RTL
========================

// Module: cdc_event_scheduler
// PURPOSE
//  Shares one bundled-data crossing channel (ch_req/ch_id out, ch_ack back) between N_REQ event sources.
//  Each source raises single-cycle event pulses; the block latches them, grants them round-robin and runs a
//  4-phase req/ack handshake so each event reaches the far domain as a stretched, lossless pulse plus its id.
//  Sits in the source domain, in front of the pulse-stretcher/synchronizer pair that carries ch_req across.
// PARAMETERS
//  N_REQ      4    number of event sources (2..16); IDW = max(1,$clog2(N_REQ)) derived
//  SETUP_CYC  2    cycles ch_id is stable before ch_req rises (1..15)
//  TO_CYC     255  cycles to wait for each ack edge before timeout; 0 disables timeout
// PORTS
//  clk       in   1      source-domain clock, all state on rising edge
//  rst_n     in   1      asynchronous active-low reset
//  ev_in     in   N_REQ  per-source event pulse, one clk wide
//  ch_ack    in   1      far-side ack, already 2-flop synchronized into clk
//  ovf_clr   in   1      clears ovf and err when high
//  ch_req    out  1      channel request (registered)
//  ch_id     out  IDW    id of granted source, stable from SETUP through REL
//  ev_pend   out  N_REQ  latched, not-yet-granted events
//  busy      out  1      FSM not in IDLE
//  ovf       out  N_REQ  sticky: event arrived while same source already pending
//  err       out  2      sticky: [0] ack timeout, [1] ack high while IDLE
// BEHAVIOUR
//  Reset: ch_req=0, ch_id=0, ev_pend=0, ovf=0, err=0, busy=0, FSM=IDLE, rr pointer=N_REQ-1 (src 0 wins first).
//  ch_req drops asynchronously with rst_n; reset mid-handshake abandons the transfer, no pending kept.
//  Pending: ev_pend[i] set by ev_in[i]; cleared in the cycle source i is granted. ev_in[i] in the grant
//   cycle of i sets it again (set wins). ev_in[i] while ev_pend[i]=1 and not granted -> ovf[i]=1, event merged.
//  FSM (registered outputs, transitions on rising clk):
//   IDLE  : if |ev_pend -> grant rr winner, load ch_id, ctr=SETUP_CYC-1, -> SETUP. Else stay.
//           ch_ack=1 in IDLE sets err[1]; FSM stays IDLE until ack low before next grant.
//   SETUP : ctr counts down; at 0 -> REQ, ch_req=1 (first req high = SETUP_CYC cycles after grant).
//   REQ   : hold ch_req=1 until ch_ack=1 -> REL, ch_req=0 next cycle.
//   REL   : hold ch_req=0 until ch_ack=0 -> IDLE. Earliest next grant the cycle after IDLE entry.
//   Timeout: in REQ or REL, TO_CYC consecutive cycles without the awaited ack level -> err[0]=1,
//    ch_req=0, -> IDLE; the event is dropped (not re-pended).
//  Round-robin: search starts at ptr+1 mod N_REQ; ptr := granted index. Pure priority only within one scan.
//  Counters: SETUP ctr 4 bits, timeout ctr 8 bits min (width from TO_CYC), saturating, reset on state change.
//  ovf_clr and a new ovf/err set in same cycle: set wins.
//  Min handshake: SETUP_CYC + 1 + 2*sync latency cycles; throughput bounded by far-side ack.
// STRUCTURE
//  cdc_pkg: FSM state encoding (IDLE,SETUP,REQ,REL), err bit indices, IDW helper function.
//  Sub-module rr_arbiter (N_REQ): req vector + ptr -> one-hot grant, index, any; combinational.
//  Top: pending/ovf regs, FSM, SETUP and timeout counters, output regs.
// TESTING
//  1 single event: ev_in=4'b0100, ack responds 3 cycles after req -> ch_id=2, req high 2 cycles after grant, one handshake, ev_pend=0.
//  2 fairness: all four sources pulse together after reset -> grant order 0,1,2,3; repeat -> again 0,1,2,3.
//  3 overflow: ev_in[1] twice while src 0 is in REQ -> one transfer for id 1, ovf=4'b0010; ovf_clr -> 0.
//  4 set-wins: ev_in[3] in the exact cycle src 3 is granted -> id 3 sent twice, ovf[3]=0.
//  5 timeout: TO_CYC=8, ack never rises -> req low after 8 REQ cycles, err=2'b01, next pending source served.
//  6 reset mid-REQ: rst_n low while ch_req=1 -> ch_req=0 immediately, ev_pend=0; first grant after release is src 0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the event scheduler that feeds one bundled-data crossing channel.
// FSM encoding, error bit positions and width helpers live here so the arbiter and top agree.
package cdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_REQ   = 2'd2,
      ST_REL   = 2'd3
   } state_e;

   localparam int ERR_TO       = 0;
   localparam int ERR_ACK_IDLE = 1;

   function automatic int idw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Timeout counter never narrower than 8 bits.
   function automatic int tow(input int to_cyc);
      int w;
      w = $clog2(to_cyc + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scan starts just above ptr_i and wraps,
// so the most recently granted source has the lowest priority in the next scan.
module rr_arbiter
   import cdc_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = idw(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic [N_REQ-1:0] gnt_oh_o,
   output logic [IDW-1:0]   gnt_idx_o,
   output logic             any_o
);

   logic           found_hi;
   logic           found_lo;
   logic [IDW-1:0] idx_hi;
   logic [IDW-1:0] idx_lo;

   // Two masked priority scans: lowest request above the pointer, else lowest overall.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            found_lo = 1'b1;
            idx_lo   = IDW'(i);
            if (i > int'(ptr_i)) begin
               found_hi = 1'b1;
               idx_hi   = IDW'(i);
            end
         end
      end
   end

   assign any_o     = found_lo;
   assign gnt_idx_o = found_hi ? idx_hi : idx_lo;
   assign gnt_oh_o  = found_lo ? (N_REQ'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/cdc_event_scheduler.sv
// Latches single-cycle events from N_REQ sources and serialises them, round-robin, over one
// 4-phase req/ack channel (ch_req/ch_id out, synchronized ch_ack back) toward a far clock domain.
module cdc_event_scheduler
   import cdc_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int SETUP_CYC = 2,
   parameter  int TO_CYC    = 255,
   localparam int IDW       = idw(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] ev_in,
   input  logic             ch_ack,
   input  logic             ovf_clr,
   output logic             ch_req,
   output logic [IDW-1:0]   ch_id,
   output logic [N_REQ-1:0] ev_pend,
   output logic             busy,
   output logic [N_REQ-1:0] ovf,
   output logic [1:0]       err
);

   localparam int TOW = tow(TO_CYC);

   state_e           state_q,   state_d;
   logic [3:0]       setup_q,   setup_d;
   logic [TOW-1:0]   to_q,      to_d;
   logic             ch_req_q,  ch_req_d;
   logic [IDW-1:0]   ch_id_q,   ch_id_d;
   logic [IDW-1:0]   ptr_q,     ptr_d;
   logic [N_REQ-1:0] pend_q,    pend_d;
   logic [N_REQ-1:0] ovf_q,     ovf_d;
   logic [1:0]       err_q,     err_d;

   logic [N_REQ-1:0] gnt_oh;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_any;
   logic             grant;
   logic             to_hit;
   logic             to_err;
   logic [N_REQ-1:0] gnt_clr;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_i     (pend_q),
      .ptr_i     (ptr_q),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   // A lingering ack in IDLE blocks new grants until the far side has released it.
   assign grant   = (state_q == ST_IDLE) && gnt_any && !ch_ack;
   assign to_hit  = (TO_CYC != 0) && (to_q == TOW'(TO_CYC - 1));
   assign gnt_clr = grant ? gnt_oh : '0;

   always_comb begin
      state_d  = state_q;
      setup_d  = setup_q;
      ch_req_d = ch_req_q;
      ch_id_d  = ch_id_q;
      ptr_d    = ptr_q;
      to_err   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_SETUP;
               ch_id_d = gnt_idx;
               ptr_d   = gnt_idx;
               setup_d = 4'(SETUP_CYC - 1);
            end
         end
         ST_SETUP: begin
            if (setup_q == 4'd0) begin
               state_d  = ST_REQ;
               ch_req_d = 1'b1;
            end else begin
               setup_d = setup_q - 4'd1;
            end
         end
         ST_REQ: begin
            if (ch_ack) begin
               state_d  = ST_REL;
               ch_req_d = 1'b0;
            end else if (to_hit) begin
               state_d  = ST_IDLE;
               ch_req_d = 1'b0;
               to_err   = 1'b1;
            end
         end
         ST_REL: begin
            if (!ch_ack) begin
               state_d = ST_IDLE;
            end else if (to_hit) begin
               state_d = ST_IDLE;
               to_err  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Any ack edge changes state, so a counter that restarts on state change measures the wait.
   always_comb begin
      to_d = to_q;
      if (state_d != state_q) begin
         to_d = '0;
      end else if (to_q != '1) begin
         to_d = to_q + TOW'(1);
      end
   end

   // New events always win over the grant clear and over ovf_clr.
   always_comb begin
      pend_d = (pend_q & ~gnt_clr) | ev_in;
      ovf_d  = (ovf_clr ? '0 : ovf_q) | (ev_in & pend_q & ~gnt_clr);
      err_d  = ovf_clr ? 2'b00 : err_q;
      err_d[ERR_TO]       = err_d[ERR_TO] | to_err;
      err_d[ERR_ACK_IDLE] = err_d[ERR_ACK_IDLE] | ((state_q == ST_IDLE) && ch_ack);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         setup_q  <= '0;
         to_q     <= '0;
         ch_req_q <= 1'b0;
         ch_id_q  <= '0;
         ptr_q    <= IDW'(N_REQ - 1);
         pend_q   <= '0;
         ovf_q    <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         setup_q  <= setup_d;
         to_q     <= to_d;
         ch_req_q <= ch_req_d;
         ch_id_q  <= ch_id_d;
         ptr_q    <= ptr_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign ch_req  = ch_req_q;
   assign ch_id   = ch_id_q;
   assign ev_pend = pend_q;
   assign busy    = (state_q != ST_IDLE);
   assign ovf     = ovf_q;
   assign err     = err_q;

endmodule
